// File: rtl/ahb_lite_pkg.sv
// Shared AHB-Lite encodings and the copy-master state enum.
// Imported by the copy master and available to any other AHB initiator in the slice.
package ahb_lite_pkg;

  localparam logic [1:0] HTRANS_IDLE     = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ   = 2'b10;
  localparam logic [2:0] HSIZE_WORD      = 3'b010;
  localparam logic [2:0] HBURST_SINGLE   = 3'b000;
  localparam logic [3:0] HPROT_DATA_PRIV = 4'b0011;
  localparam logic       HRESP_OKAY      = 1'b0;
  localparam logic       HRESP_ERROR     = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD_A = 3'd1,
    ST_RD_D = 3'd2,
    ST_WR_A = 3'd3,
    ST_WR_D = 3'd4,
    ST_FIN  = 3'd5
  } copy_state_e;

endpackage

// File: rtl/ahb_lite_copy_master.sv
// AHB-Lite initiator copying 32-bit words from a fixed or incrementing source to an
// incrementing destination, one non-pipelined read/write pair per word.
module ahb_lite_copy_master
  import ahb_lite_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [CNT_W-1:0]  word_count,
  input  logic              src_inc,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [CNT_W-1:0]  words_done,
  output logic [ADDR_W-1:0] HADDR,
  output logic [1:0]        HTRANS,
  output logic              HWRITE,
  output logic [2:0]        HSIZE,
  output logic [2:0]        HBURST,
  output logic [3:0]        HPROT,
  output logic              HMASTLOCK,
  output logic [DATA_W-1:0] HWDATA,
  input  logic [DATA_W-1:0] HRDATA,
  input  logic              HREADY,
  input  logic              HRESP
);

  localparam int WA_W = ADDR_W - 2;
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  // Addresses are kept as word addresses so bits[1:0] can never be non-zero on the bus.
  function automatic logic [ADDR_W-1:0] byte_addr(input logic [WA_W-1:0] wa);
    return {wa, 2'b00};
  endfunction

  copy_state_e       state_r;
  logic [WA_W-1:0]   src_wa_r;
  logic [WA_W-1:0]   dst_wa_r;
  logic [CNT_W-1:0]  remaining_r;
  logic              src_inc_r;
  logic              abort_pend_r;
  logic              busy_r;
  logic              done_r;
  logic              err_r;
  logic [CNT_W-1:0]  words_done_r;
  logic [ADDR_W-1:0] haddr_r;
  logic [1:0]        htrans_r;
  logic              hwrite_r;
  logic [DATA_W-1:0] hwdata_r;
  logic [WA_W-1:0]   src_nxt_s;
  logic [WA_W-1:0]   dst_nxt_s;
  logic              unused_s;

  assign src_nxt_s = src_wa_r + {{(WA_W-1){1'b0}}, src_inc_r};
  assign dst_nxt_s = dst_wa_r + {{(WA_W-1){1'b0}}, 1'b1};
  assign unused_s  = ^{src_addr[1:0], dst_addr[1:0]};

  // Copy FSM with all bus-facing outputs registered alongside the state.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_r      <= ST_IDLE;
      src_wa_r     <= {WA_W{1'b0}};
      dst_wa_r     <= {WA_W{1'b0}};
      remaining_r  <= CNT_ZERO;
      src_inc_r    <= 1'b0;
      abort_pend_r <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      err_r        <= 1'b0;
      words_done_r <= CNT_ZERO;
      haddr_r      <= {ADDR_W{1'b0}};
      htrans_r     <= HTRANS_IDLE;
      hwrite_r     <= 1'b0;
      hwdata_r     <= {DATA_W{1'b0}};
    end else begin
      done_r <= 1'b0;
      if (abort && (state_r != ST_IDLE)) begin
        abort_pend_r <= 1'b1;
      end
      case (state_r)
        ST_IDLE: begin
          abort_pend_r <= 1'b0;
          if (start) begin
            src_wa_r     <= src_addr[ADDR_W-1:2];
            dst_wa_r     <= dst_addr[ADDR_W-1:2];
            remaining_r  <= word_count;
            src_inc_r    <= src_inc;
            err_r        <= 1'b0;
            words_done_r <= CNT_ZERO;
            busy_r       <= 1'b1;
            if (word_count != CNT_ZERO) begin
              state_r  <= ST_RD_A;
              htrans_r <= HTRANS_NONSEQ;
              hwrite_r <= 1'b0;
              haddr_r  <= byte_addr(src_addr[ADDR_W-1:2]);
            end else begin
              state_r <= ST_FIN;
              done_r  <= 1'b1;
            end
          end
        end
        ST_RD_A: begin
          if (HREADY) begin
            state_r  <= ST_RD_D;
            htrans_r <= HTRANS_IDLE;
          end
        end
        ST_RD_D: begin
          // ERROR is acted on only in its second (HREADY=1) cycle; IDLE is already on the bus.
          if (HREADY) begin
            if (HRESP == HRESP_ERROR) begin
              err_r   <= 1'b1;
              state_r <= ST_FIN;
              done_r  <= 1'b1;
            end else begin
              hwdata_r <= HRDATA;
              state_r  <= ST_WR_A;
              htrans_r <= HTRANS_NONSEQ;
              hwrite_r <= 1'b1;
              haddr_r  <= byte_addr(dst_wa_r);
            end
          end
        end
        ST_WR_A: begin
          if (HREADY) begin
            state_r  <= ST_WR_D;
            htrans_r <= HTRANS_IDLE;
          end
        end
        ST_WR_D: begin
          if (HREADY) begin
            if (HRESP == HRESP_ERROR) begin
              err_r   <= 1'b1;
              state_r <= ST_FIN;
              done_r  <= 1'b1;
            end else begin
              words_done_r <= words_done_r + CNT_ONE;
              dst_wa_r     <= dst_nxt_s;
              src_wa_r     <= src_nxt_s;
              remaining_r  <= remaining_r - CNT_ONE;
              if ((remaining_r == CNT_ONE) || abort_pend_r) begin
                state_r <= ST_FIN;
                done_r  <= 1'b1;
              end else begin
                state_r  <= ST_RD_A;
                htrans_r <= HTRANS_NONSEQ;
                hwrite_r <= 1'b0;
                haddr_r  <= byte_addr(src_nxt_s);
              end
            end
          end
        end
        ST_FIN: begin
          busy_r       <= 1'b0;
          abort_pend_r <= 1'b0;
          state_r      <= ST_IDLE;
        end
        default: begin
          busy_r   <= 1'b0;
          htrans_r <= HTRANS_IDLE;
          state_r  <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy       = busy_r;
  assign done       = done_r;
  assign err        = err_r;
  assign words_done = words_done_r;
  assign HADDR      = haddr_r;
  assign HTRANS     = htrans_r;
  assign HWRITE     = hwrite_r;
  assign HWDATA     = hwdata_r;
  assign HSIZE      = HSIZE_WORD;
  assign HBURST     = HBURST_SINGLE;
  assign HPROT      = HPROT_DATA_PRIV;
  assign HMASTLOCK  = 1'b0;

endmodule

// File: tb/tb_ahb_lite_copy_master.sv
// Randomised bench for ahb_lite_copy_master: a behavioural AHB slave with wait/error
// injection, and a job-level model predicting addresses, data, counts and done timing.
module tb_ahb_lite_copy_master;

  logic        HCLK;
  logic        HRESET;
  logic        start;
  logic        abort;
  logic [31:0] src_addr;
  logic [31:0] dst_addr;
  logic [15:0] word_count;
  logic        src_inc;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] words_done;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic        HMASTLOCK;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;

  ahb_lite_copy_master dut (
    .HCLK(HCLK), .HRESET(HRESET), .start(start), .abort(abort),
    .src_addr(src_addr), .dst_addr(dst_addr), .word_count(word_count), .src_inc(src_inc),
    .busy(busy), .done(done), .err(err), .words_done(words_done),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
    .HPROT(HPROT), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA), .HRDATA(HRDATA),
    .HREADY(HREADY), .HRESP(HRESP)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Slave configuration and transaction logs for the current job
  logic [31:0] job_data[$];
  logic [31:0] act_rd_addr[$];
  logic [31:0] act_wr_addr[$];
  logic [31:0] act_wr_data[$];
  int cfg_wait = 0;
  int cfg_err_rd = -1;
  int cfg_err_wr = -1;
  int rd_idx = 0;
  int wr_idx = 0;

  bit          sl_active = 1'b0;
  bit          sl_write;
  bit          sl_err;
  logic [31:0] sl_addr;
  int          sl_idx;
  int          sl_wait;
  int          sl_cyc;
  logic [31:0] sl_prev_addr = 32'h0;
  logic        sl_prev_write = 1'b0;
  logic        nxt_ready;
  logic        nxt_resp;
  logic [31:0] nxt_rdata;

  // Behavioural slave: observes at negedge, drives next-cycle response just after posedge.
  initial begin
    HREADY = 1'b1; HRESP = 1'b0; HRDATA = 32'h0;
    forever begin
      @(negedge HCLK);
      nxt_ready = 1'b1; nxt_resp = 1'b0; nxt_rdata = 32'h0;
      if (HRESET) begin
        sl_active = 1'b0;
      end else begin
        if (sl_active) begin
          check_val("htrans_idle_in_data_phase", 32'(HTRANS), 32'h0);
          if (!HREADY) begin
            check_val("haddr_hold", HADDR, sl_prev_addr);
            check_val("hwrite_hold", 32'(HWRITE), 32'(sl_prev_write));
          end else begin
            if (!HRESP && sl_write) begin
              act_wr_addr.push_back(sl_addr);
              act_wr_data.push_back(HWDATA);
            end
            sl_active = 1'b0;
          end
        end
        if (HTRANS == 2'b10 && HREADY) begin
          check_val("haddr_align", 32'(HADDR[1:0]), 32'h0);
          sl_active = 1'b1; sl_write = HWRITE; sl_addr = HADDR; sl_cyc = 0;
          if (HWRITE) begin
            sl_err = (wr_idx == cfg_err_wr); sl_idx = wr_idx; wr_idx++; sl_wait = 0;
          end else begin
            sl_err = (rd_idx == cfg_err_rd); sl_idx = rd_idx; rd_idx++; sl_wait = cfg_wait;
            act_rd_addr.push_back(HADDR);
          end
        end
        sl_prev_addr = HADDR; sl_prev_write = HWRITE;
        if (sl_active) begin
          if (sl_cyc < sl_wait) begin
            nxt_ready = 1'b0;
          end else if (sl_err) begin
            nxt_resp = 1'b1; nxt_ready = (sl_cyc > sl_wait);
          end else if (!sl_write) begin
            nxt_rdata = (sl_idx < job_data.size()) ? job_data[sl_idx] : 32'hDEAD_BEEF;
          end
          sl_cyc++;
        end
      end
      @(posedge HCLK);
      #1;
      HREADY = nxt_ready; HRESP = nxt_resp; HRDATA = nxt_rdata;
    end
  end

  task automatic fill_data(input int n);
    job_data.delete();
    for (int i = 0; i < n; i++) job_data.push_back($urandom);
  endtask

  // Runs one job and checks it against the model derived from the job parameters.
  task automatic run_job(input logic [31:0] src, input logic [31:0] dst, input int count,
                         input logic inc, input int w, input int err_rd, input int err_wr,
                         input int abort_w, input bit poke);
    int words, reads, exp_done, abort_cyc;
    logic exp_err;
    logic [31:0] a;
    exp_err = 1'b0; abort_cyc = -1;
    if (err_rd >= 0 && err_rd < count) begin
      words = err_rd; reads = err_rd + 1; exp_err = 1'b1;
      exp_done = 1 + err_rd * (w + 4) + (w + 3);
    end else if (err_wr >= 0 && err_wr < count) begin
      words = err_wr; reads = err_wr + 1; exp_err = 1'b1;
      exp_done = 1 + err_wr * (w + 4) + (w + 5);
    end else if (abort_w >= 0 && abort_w < count) begin
      words = abort_w + 1; reads = words;
      exp_done = 1 + words * (w + 4);
      abort_cyc = 2 + abort_w * (w + 4);
    end else begin
      words = count; reads = count;
      exp_done = 1 + count * (w + 4);
    end
    cfg_wait = w; cfg_err_rd = err_rd; cfg_err_wr = err_wr; rd_idx = 0; wr_idx = 0;
    act_rd_addr.delete(); act_wr_addr.delete(); act_wr_data.delete();
    @(posedge HCLK); #1;
    start = 1'b1; src_addr = src; dst_addr = dst; word_count = 16'(count); src_inc = inc;
    @(posedge HCLK); #1;
    start = 1'b0;
    for (int cyc = 1; cyc <= exp_done + 2; cyc++) begin
      abort = (cyc == abort_cyc);
      if (poke && cyc == 2 && exp_done >= 2) begin
        start = 1'b1; src_addr = $urandom; dst_addr = $urandom; word_count = 16'd7;
      end else begin
        start = 1'b0;
      end
      @(negedge HCLK);
      check_val("busy", 32'(busy), (cyc <= exp_done) ? 32'd1 : 32'd0);
      check_val("done", 32'(done), (cyc == exp_done) ? 32'd1 : 32'd0);
      @(posedge HCLK); #1;
    end
    abort = 1'b0; start = 1'b0;
    check_val("words_done", 32'(words_done), 32'(words));
    check_val("err", 32'(err), 32'(exp_err));
    check_val("htrans_after", 32'(HTRANS), 32'h0);
    check_val("hsize", 32'(HSIZE), 32'h2);
    check_val("hburst", 32'(HBURST), 32'h0);
    check_val("hprot", 32'(HPROT), 32'h3);
    check_val("hmastlock", 32'(HMASTLOCK), 32'h0);
    check_val("n_reads", 32'(act_rd_addr.size()), 32'(reads));
    check_val("n_writes", 32'(act_wr_addr.size()), 32'(words));
    for (int i = 0; i < reads && i < act_rd_addr.size(); i++) begin
      a = (src & 32'hFFFF_FFFC) + (inc ? 32'(i) * 32'd4 : 32'd0);
      check_val("rd_addr", act_rd_addr[i], a);
    end
    for (int i = 0; i < words && i < act_wr_addr.size(); i++) begin
      a = (dst & 32'hFFFF_FFFC) + 32'(i) * 32'd4;
      check_val("wr_addr", act_wr_addr[i], a);
      check_val("wr_data", act_wr_data[i], job_data[i]);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, mode, idx;
    HRESET = 1'b1; start = 1'b0; abort = 1'b0;
    src_addr = 32'h0; dst_addr = 32'h0; word_count = 16'h0; src_inc = 1'b0;
    repeat (2) @(posedge HCLK);
    #1;
    check_val("rst_htrans", 32'(HTRANS), 32'h0);
    check_val("rst_haddr", HADDR, 32'h0);
    check_val("rst_hwrite", 32'(HWRITE), 32'h0);
    check_val("rst_hwdata", HWDATA, 32'h0);
    check_val("rst_busy", 32'(busy), 32'h0);
    check_val("rst_done", 32'(done), 32'h0);
    check_val("rst_err", 32'(err), 32'h0);
    check_val("rst_words_done", 32'(words_done), 32'h0);
    HRESET = 1'b0;

    // FIFO drain into SRAM
    job_data.delete();
    job_data.push_back(32'hA1); job_data.push_back(32'hB2); job_data.push_back(32'hC3);
    run_job(32'h4000_0000, 32'h2000_0100, 3, 1'b0, 0, -1, -1, -1, 1'b0);
    // Zero-length job
    run_job(32'h4000_0000, 32'h2000_0100, 0, 1'b0, 0, -1, -1, -1, 1'b0);
    // Read wait states
    fill_data(4);
    run_job(32'h1000_0000, 32'h2000_0000, 4, 1'b1, 2, -1, -1, -1, 1'b0);
    // ERROR on second write
    fill_data(3);
    run_job(32'h4000_0000, 32'h2000_0200, 3, 1'b0, 0, -1, 1, -1, 1'b0);
    // Abort during second read
    fill_data(5);
    run_job(32'h4000_0000, 32'h2000_0300, 5, 1'b0, 0, -1, -1, 1, 1'b1);

    // Reset while in the first write data phase
    job_data.delete();
    job_data.push_back(32'h5A5A_1234); job_data.push_back(32'h1); job_data.push_back(32'h2);
    cfg_wait = 0; cfg_err_rd = -1; cfg_err_wr = -1; rd_idx = 0; wr_idx = 0;
    @(posedge HCLK); #1;
    start = 1'b1; src_addr = 32'h4000_0000; dst_addr = 32'h2000_0400;
    word_count = 16'd3; src_inc = 1'b0;
    @(posedge HCLK); #1;
    start = 1'b0;
    repeat (3) @(posedge HCLK);
    #1;
    check_val("pre_rst_hwrite", 32'(HWRITE), 32'h1);
    check_val("pre_rst_hwdata", HWDATA, 32'h5A5A_1234);
    #3;
    HRESET = 1'b1;
    #1;
    check_val("mid_rst_htrans", 32'(HTRANS), 32'h0);
    check_val("mid_rst_haddr", HADDR, 32'h0);
    check_val("mid_rst_hwrite", 32'(HWRITE), 32'h0);
    check_val("mid_rst_hwdata", HWDATA, 32'h0);
    check_val("mid_rst_busy", 32'(busy), 32'h0);
    check_val("mid_rst_words_done", 32'(words_done), 32'h0);
    repeat (3) @(posedge HCLK);
    #1;
    HRESET = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge HCLK);
      check_val("post_rst_done", 32'(done), 32'h0);
      check_val("post_rst_busy", 32'(busy), 32'h0);
    end
    // Incrementing source wraps through zero
    fill_data(2);
    run_job(32'hFFFF_FFFC, 32'h3000_0000, 2, 1'b1, 0, -1, -1, -1, 1'b0);

    for (int j = 0; j < 40; j++) begin
      cnt  = $urandom_range(0, 6);
      mode = (cnt == 0) ? 0 : $urandom_range(0, 3);
      idx  = (cnt == 0) ? 0 : $urandom_range(0, cnt - 1);
      fill_data(cnt);
      run_job($urandom, $urandom, cnt, 1'($urandom_range(0, 1)), $urandom_range(0, 3),
              (mode == 1) ? idx : -1, (mode == 2) ? idx : -1, (mode == 3) ? idx : -1,
              1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
